// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam int STREAK_MAX_DEF = 2;

endpackage

// File: rtl/sram_arb_resp.sv
// Response tracker: remembers who owned last cycle's SRAM access and steers
// the returning read data to that requester, dropping flushed fetches.
//
// state    | meaning
// ---------+--------------------------------------------------
// OWN_NONE | no access last cycle, no response this cycle
// OWN_INST | last cycle's access was a fetch; deliver inst_done
// OWN_DATA | last cycle's access was a load/store; deliver data_done
module sram_arb_resp
  import sram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_gnt,
  input  logic        data_gnt,
  input  logic        data_read,
  input  logic        inst_flush,
  input  logic [31:0] sram_rdata,
  output logic        inst_done,
  output logic [31:0] inst_rdata,
  output logic        data_done,
  output logic [31:0] data_rdata
);

  owner_e state_q, state_d;
  logic   kill_q;
  logic   rd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= OWN_NONE;
      kill_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= inst_gnt & inst_flush;
      rd_q    <= data_gnt & data_read;
    end
  end

  always_comb begin
    state_d    = OWN_NONE;
    inst_done  = 1'b0;
    inst_rdata = 32'h0;
    data_done  = 1'b0;
    data_rdata = 32'h0;
    if (inst_gnt)
      state_d = OWN_INST;
    else if (data_gnt)
      state_d = OWN_DATA;

    case (state_q)
      OWN_INST: begin
        // a flush in either the grant cycle or this one kills the fetch
        inst_done  = ~kill_q & ~inst_flush;
        inst_rdata = sram_rdata;
      end
      OWN_DATA: begin
        data_done  = 1'b1;
        data_rdata = rd_q ? sram_rdata : 32'h0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one SRAM port,
// data first, with a streak limit so fetches cannot starve.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_flush,
  output logic          inst_gnt,
  output logic          inst_done,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_gnt,
  output logic          data_done,
  output logic [31:0]   data_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam logic [2:0] STREAK_LIM = 3'(STREAK_MAX);

  logic [2:0] streak_q;
  logic       inst_pri;

  // grants are gated by resetn so nothing reaches the SRAM while in reset
  assign inst_pri = inst_req & ~inst_flush & (streak_q == STREAK_LIM);
  assign data_gnt = resetn & data_req & ~inst_pri;
  assign inst_gnt = resetn & inst_req & ~inst_flush & ~data_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      streak_q <= 3'd0;
    else if (inst_gnt || !inst_req)
      streak_q <= 3'd0;
    else if (data_gnt && streak_q < STREAK_LIM)
      streak_q <= streak_q + 3'd1;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end
  end

  sram_arb_resp u_resp (
    .clk        (clk),
    .resetn     (resetn),
    .inst_gnt   (inst_gnt),
    .data_gnt   (data_gnt),
    .data_read  (data_wen == 4'b0000),
    .inst_flush (inst_flush),
    .sram_rdata (sram_rdata),
    .inst_done  (inst_done),
    .inst_rdata (inst_rdata),
    .data_done  (data_done),
    .data_rdata (data_rdata)
  );

endmodule
